// File: rtl/out_arb_pkg.sv
// Shared types and widths for the output-port arbiter.
// The HOLD state only exists when OUT_ARB_HOLD_EN is defined.
package out_arb_pkg;

   localparam int DATA_W     = 4;
   localparam int HOLD_CNT_W = 4;

`ifdef OUT_ARB_HOLD_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1
   } state_t;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request selector: searches upward from ptr, wrapping at NREQ-1,
// and returns the first set request as a one-hot grant plus its index.
module rr_arbiter #(
   parameter int NREQ  = 3,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx
);

   logic             found;
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NREQ)) begin
            sum = sum - (IDX_W+1)'(NREQ);
         end
         cand = sum[IDX_W-1:0];
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/out_port_arbiter.sv
// Shares one 4-bit output register among NREQ requesters with round-robin grants.
// Define OUT_ARB_HOLD_EN to add a HOLD state keeping each value for HOLD_CYCLES.
//
// state | meaning
// IDLE  | waiting for any Req; grant captures winner data into IB
// LOAD  | LoadOut and Ack[winner] high for one cycle
// HOLD  | value held on IB for HOLD_CYCLES cycles, Req ignored
module out_port_arbiter
   import out_arb_pkg::*;
#(
   parameter int NREQ        = 3,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                     MainClock,
   input  logic                     MainReset,
   input  logic [NREQ-1:0]          Req,
   input  logic [DATA_W*NREQ-1:0]   ReqData,
   output logic [NREQ-1:0]          Ack,
   output logic [DATA_W-1:0]        IB,
   output logic                     LoadOut,
   output logic                     Busy
);

   localparam int IDX_W = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 4) begin : g_nreq_chk
      $error("out_port_arbiter: NREQ must be 2..4");
   end
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_hold_chk
      $error("out_port_arbiter: HOLD_CYCLES must be 1..15");
   end

   state_t            state, state_nxt;
   logic              grant_en;
   logic [IDX_W-1:0]  ptr, win_idx;
   logic [NREQ-1:0]   win_grant, ack_q;
   logic [DATA_W-1:0] win_data;

   rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
      .req   (Req),
      .ptr   (ptr),
      .grant (win_grant),
      .idx   (win_idx)
   );

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_data = ReqData[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef OUT_ARB_HOLD_EN
   localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);
   logic [HOLD_CNT_W-1:0] hold_cnt;
`endif

   always_comb begin
      state_nxt = state;
      grant_en  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|Req) begin
               grant_en  = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
`ifdef OUT_ARB_HOLD_EN
         ST_LOAD: state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (hold_cnt == '0) begin
               state_nxt = ST_IDLE;
            end
         end
`else
         ST_LOAD: state_nxt = ST_IDLE;
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Pointer advances at grant time; a reset before Ack zeroes it anyway.
   always_ff @(posedge MainClock) begin
      if (MainReset) begin
         state <= ST_IDLE;
         ptr   <= '0;
         ack_q <= '0;
         IB    <= '0;
      end else begin
         state <= state_nxt;
         if (grant_en) begin
            IB    <= win_data;
            ack_q <= win_grant;
            ptr   <= (win_idx == IDX_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
         end
      end
   end

`ifdef OUT_ARB_HOLD_EN
   always_ff @(posedge MainClock) begin
      if (MainReset) begin
         hold_cnt <= '0;
      end else if (state == ST_LOAD) begin
         hold_cnt <= HOLD_LOAD;
      end else if (state == ST_HOLD && hold_cnt != '0) begin
         hold_cnt <= hold_cnt - 1'b1;
      end
   end
`endif

   // Reset in the LOAD cycle suppresses the strobe so an aborted write is never acked.
   assign LoadOut = (state == ST_LOAD) && !MainReset;
   assign Ack     = LoadOut ? ack_q : '0;
   assign Busy    = (state != ST_IDLE);

endmodule

// File: doc/out_port_arbiter.md
OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing the 4-bit output register (2..4).
REQ-002 Parameter HOLD_CYCLES, default 4, minimum cycles a written value stays on the output before the next grant (1..15); used only with OUT_ARB_HOLD_EN.
REQ-003 MainClock  in  1  single clock; all state changes on rising edge.
REQ-004 MainReset  in  1  reset, synchronous, active-high.
REQ-005 Req  in  NREQ  per-requester write request; level, held until matching Ack.
REQ-006 ReqData  in  4*NREQ  4-bit data per requester; slice i = [4i+3:4i].
REQ-007 Ack  out  NREQ  one-cycle grant-complete pulse, one-hot.
REQ-008 IB  out  4  data bus to the output register's IB3..IB0 inputs.
REQ-009 LoadOut  out  1  one-cycle load strobe to the output register.
REQ-010 Busy  out  1  high whenever state is not IDLE.

Function
REQ-011 FSM states: IDLE, LOAD, HOLD (HOLD exists only with OUT_ARB_HOLD_EN).
REQ-012 IDLE, no Req bit set: stay IDLE; LoadOut, Ack low; IB holds last value.
REQ-013 IDLE, any Req bit set: pick winner by round-robin; register IB <= winner's ReqData slice; go to LOAD next edge.
REQ-014 LOAD: LoadOut=1 and Ack[winner]=1 for exactly this one cycle; IB stable throughout.
REQ-015 LOAD -> HOLD with OUT_ARB_HOLD_EN; LOAD -> IDLE without it.
REQ-016 HOLD: 4-bit counter counts HOLD_CYCLES cycles, then -> IDLE; Req ignored during HOLD.
REQ-017 Round-robin: priority pointer starts at 0; after granting i, highest priority becomes (i+1) mod NREQ; search wraps from NREQ-1 to 0.
REQ-018 Single requester held high continuously is re-granted every pass through IDLE (no starvation of itself by the pointer).
REQ-019 Grant-to-LoadOut latency: 1 cycle (Req sampled in IDLE at edge N, LoadOut high in cycle N+1).
REQ-020 Req dropped after grant but before Ack: transaction still completes with data captured at grant.
REQ-021 ReqData changing after grant has no effect on IB.
REQ-022 Req bits outside NREQ are never produced; Ack is always one-hot or zero.
REQ-023 IB changes only on the edge entering LOAD; never while LoadOut is high.

Reset
REQ-024 MainReset high at an edge: state=IDLE, IB=4'b0000, LoadOut=0, Ack=0, Busy=0, pointer=0, hold counter=0.
REQ-025 Reset during LOAD or HOLD aborts the transaction: no Ack issued for it; the requester must re-request.
REQ-026 Reset overrides all other inputs in the same cycle; first grant possible the cycle after reset deasserts.

Configuration
REQ-027 Macro OUT_ARB_HOLD_EN defined: HOLD state and counter compiled in; back-to-back writes spaced by 2+HOLD_CYCLES cycles.
REQ-028 Macro OUT_ARB_HOLD_EN undefined: no HOLD state, no counter; back-to-back writes spaced by 2 cycles; HOLD_CYCLES ignored.

Structure
REQ-029 Shared package out_arb_pkg holds the FSM state enum typedef, the 4-bit data width constant, and the hold-counter width constant.
REQ-030 Round-robin selection lives in sub-module rr_arbiter (inputs req vector + pointer, output one-hot grant + index); FSM, data mux and counter stay in out_port_arbiter.

Verification
REQ-031 Reset then Req=3'b001, ReqData[3:0]=4'hA -> LoadOut and Ack=3'b001 high exactly one cycle, one cycle after request; IB=4'hA.
REQ-032 Req=3'b111 held, data 4'h1/4'h2/4'h3 -> grants in order 0,1,2,0; IB sequence 1,2,3,1; one Ack per LoadOut.
REQ-033 OUT_ARB_HOLD_EN, HOLD_CYCLES=4, Req=3'b011 held -> LoadOut pulses exactly 6 cycles apart; without macro -> 2 cycles apart.
REQ-034 MainReset asserted in LOAD cycle -> no Ack, IB=0, pointer=0; Req still high -> re-granted one cycle after reset release.
REQ-035 Req[2] dropped and ReqData[2] changed 4'h5->4'hF after grant -> IB=4'h5, Ack[2] still pulses once.
REQ-036 Random Req traffic 1000 cycles -> scoreboard: every LoadOut paired with one Ack, IB equals granted data, no requester waits more than NREQ grants.
